// File: rtl/ram_arbitro_pkg.sv
// Shared types and default widths for the two-master RAM arbiter.
package ram_arbitro_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/ram_arbitro_rr_arbiter2.sv
// Two-requester arbiter: picks one of req0/req1 given the last granted master.
// Build option: RAM_ARB_FIXED_PRIO_EN makes master 0 win every tie.
module rr_arbiter2
    import ram_arbitro_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  req_id_t last,
    output logic    gnt0_c,
    output logic    gnt1_c
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (req0) begin
            gnt0_c = 1'b1;
        end else if (req1) begin
            gnt1_c = 1'b1;
        end
    end
`else
    // On a tie, grant the master that was not served last.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (req0 && req1) begin
            if (last == 1'b1) begin
                gnt0_c = 1'b1;
            end else begin
                gnt1_c = 1'b1;
            end
        end else if (req0) begin
            gnt0_c = 1'b1;
        end else if (req1) begin
            gnt1_c = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/ram_arbitro.sv
// Two-master sequencer in front of a single-port RAM: one access per two cycles, registered RAM port.
// Build option: RAM_ARB_FIXED_PRIO_EN (fixed priority to master 0, handled in rr_arbiter2).
module ram_arbitro
    import ram_arbitro_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] dir0,
    input  logic [ADDR_W-1:0] dir1,
    input  logic [DATA_W-1:0] datoin0,
    input  logic [DATA_W-1:0] datoin1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              valid0,
    output logic              valid1,
    output logic [DATA_W-1:0] datoout0,
    output logic [DATA_W-1:0] datoout1,
    output logic [ADDR_W-1:0] ram_dir,
    output logic [DATA_W-1:0] ram_datoin,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_datoout,
    output logic              busy
);

    state_t            state, state_n;
    req_id_t           cur_id, cur_id_n;
    req_id_t           last, last_n;
    logic              arb_g0_c, arb_g1_c;
    logic              gnt0_n, gnt1_n, valid0_n, valid1_n, ram_we_n, busy_n;
    logic [ADDR_W-1:0] ram_dir_n;
    logic [DATA_W-1:0] ram_datoin_n, datoout0_n, datoout1_n;

    rr_arbiter2 u_arb (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .gnt0_c (arb_g0_c),
        .gnt1_c (arb_g1_c)
    );

    // Next state and next register values; every output is a flop loaded here.
    always_comb begin
        state_n      = state;
        cur_id_n     = cur_id;
        last_n       = last;
        gnt0_n       = 1'b0;
        gnt1_n       = 1'b0;
        valid0_n     = 1'b0;
        valid1_n     = 1'b0;
        ram_we_n     = 1'b0;
        ram_dir_n    = ram_dir;
        ram_datoin_n = ram_datoin;
        datoout0_n   = datoout0;
        datoout1_n   = datoout1;

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (arb_g0_c || arb_g1_c) begin
                    state_n      = ACCESS;
                    cur_id_n     = req_id_t'(arb_g1_c);
                    last_n       = req_id_t'(arb_g1_c);
                    gnt0_n       = arb_g0_c;
                    gnt1_n       = arb_g1_c;
                    ram_we_n     = arb_g1_c ? we1 : we0;
                    ram_dir_n    = arb_g1_c ? dir1 : dir0;
                    ram_datoin_n = arb_g1_c ? datoin1 : datoin0;
                end
            end
            ACCESS: begin
                state_n  = DONE;
                valid0_n = (cur_id == 1'b0);
                valid1_n = (cur_id == 1'b1);
                // RAM read is combinational on the registered address: capture it now.
                if (!ram_we) begin
                    if (cur_id == 1'b1) begin
                        datoout1_n = ram_datoout;
                    end else begin
                        datoout0_n = ram_datoout;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_id     <= 1'b0;
            last       <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            valid0     <= 1'b0;
            valid1     <= 1'b0;
            ram_we     <= 1'b0;
            ram_dir    <= '0;
            ram_datoin <= '0;
            datoout0   <= '0;
            datoout1   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cur_id     <= cur_id_n;
            last       <= last_n;
            gnt0       <= gnt0_n;
            gnt1       <= gnt1_n;
            valid0     <= valid0_n;
            valid1     <= valid1_n;
            ram_we     <= ram_we_n;
            ram_dir    <= ram_dir_n;
            ram_datoin <= ram_datoin_n;
            datoout0   <= datoout0_n;
            datoout1   <= datoout1_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_ram_arbitro.sv
// Scoreboard bench for ram_arbitro with a 32x32 RAM model (pattern 32'hC0DE0000+addr at load).
module tb_ram_arbitro;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [4:0]  dir0, dir1;
    logic [31:0] datoin0, datoin1;
    logic        gnt0, gnt1, valid0, valid1, ram_we, busy;
    logic [31:0] datoout0, datoout1, ram_datoin, ram_datoout;
    logic [4:0]  ram_dir;
    logic        load_pat;
    logic [31:0] mem [32];

    typedef struct {
        logic        id;
        logic        we;
        logic [4:0]  dir;
        logic [31:0] din;
        int          cyc;
    } gnt_exp_t;

    typedef struct {
        logic        id;
        logic [4:0]  dir;
        logic [31:0] d0;
        logic [31:0] d1;
        int          cyc;
    } val_exp_t;

    gnt_exp_t gq[$];
    val_exp_t vq[$];
    gnt_exp_t g;
    val_exp_t v;
    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int base;
    int n0;

    ram_arbitro dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .dir0        (dir0),
        .dir1        (dir1),
        .datoin0     (datoin0),
        .datoin1     (datoin1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .valid0      (valid0),
        .valid1      (valid1),
        .datoout0    (datoout0),
        .datoout1    (datoout1),
        .ram_dir     (ram_dir),
        .ram_datoin  (ram_datoin),
        .ram_we      (ram_we),
        .ram_datoout (ram_datoout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (load_pat) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
        end else if (ram_we) begin
            mem[ram_dir] <= ram_datoin;
        end
    end
    assign ram_datoout = mem[ram_dir];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_g(input logic id, input logic we, input logic [4:0] dir,
                          input logic [31:0] din, input int c);
        gnt_exp_t e;
        e.id = id; e.we = we; e.dir = dir; e.din = din; e.cyc = c;
        gq.push_back(e);
    endtask

    task automatic push_v(input logic id, input logic [4:0] dir, input logic [31:0] d0,
                          input logic [31:0] d1, input int c);
        val_exp_t e;
        e.id = id; e.dir = dir; e.d0 = d0; e.d1 = d1; e.cyc = c;
        vq.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((gq.size() != 0 || vq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (gq.size() != 0 || vq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: pending gnt %0d valid %0d, expected 0 0", gq.size(), vq.size());
            gq.delete();
            vq.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: protocol invariants every cycle, scoreboard pops on each Gnt/Valid pulse.
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
            check("valid_onehot", 32'(valid0 & valid1), 32'd0);
            if (ram_we) check("we_only_in_access", 32'(gnt0 | gnt1), 32'd1);
            if (gnt0 || gnt1) begin
                if (gq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_gnt: got gnt0=%b gnt1=%b expected none", gnt0, gnt1);
                end else begin
                    g = gq.pop_front();
                    check("gnt_id", 32'(gnt1), 32'(g.id));
                    check("gnt_ram_we", 32'(ram_we), 32'(g.we));
                    check("gnt_ram_dir", 32'(ram_dir), 32'(g.dir));
                    if (g.we) check("gnt_ram_datoin", ram_datoin, g.din);
                    if (g.cyc >= 0) check("gnt_cycle", 32'(cyc), 32'(g.cyc));
                end
            end
            if (valid0 || valid1) begin
                if (vq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got valid0=%b valid1=%b expected none", valid0, valid1);
                end else begin
                    v = vq.pop_front();
                    check("valid_id", 32'(valid1), 32'(v.id));
                    check("valid_ram_dir_held", 32'(ram_dir), 32'(v.dir));
                    check("valid_ram_we_low", 32'(ram_we), 32'd0);
                    check("valid_datoout0", datoout0, v.d0);
                    check("valid_datoout1", datoout1, v.d1);
                    if (v.cyc >= 0) check("valid_cycle", 32'(cyc), 32'(v.cyc));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; load_pat = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        dir0 = '0; dir1 = '0; datoin0 = '0; datoin1 = '0;
        repeat (3) @(negedge clk);
        load_pat = 1'b0;
        check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("rst_valid", 32'({valid0, valid1}), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_datoout0", datoout0, 32'd0);
        check("rst_datoout1", datoout1, 32'd0);
        check("rst_ram_dir", 32'(ram_dir), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Master 0 writes DEADBEEF to address 5.
        base = cyc;
        req0 = 1'b1; we0 = 1'b1; dir0 = 5'd5; datoin0 = 32'hDEADBEEF;
        push_g(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, base + 1);
        push_v(1'b0, 5'd5, 32'd0, 32'd0, base + 2);
        @(negedge clk);
        check("t1_busy_access", 32'(busy), 32'd1);
        req0 = 1'b0;
        drain(10);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Master 1 reads address 5 back; master 0 data untouched.
        base = cyc;
        req1 = 1'b1; we1 = 1'b0; dir1 = 5'd5;
        push_g(1'b1, 1'b0, 5'd5, 32'd0, base + 1);
        push_v(1'b1, 5'd5, 32'd0, 32'hDEADBEEF, base + 2);
        @(negedge clk);
        req1 = 1'b0;
        drain(10);

        // Both masters held from reset release: master 0 wants two reads of addr 1, master 1 one of addr 2.
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; dir0 = 5'd1;
        req1 = 1'b1; we1 = 1'b0; dir1 = 5'd2;
        @(negedge clk);
        rst = 1'b0;
        base = cyc;
`ifdef RAM_ARB_FIXED_PRIO_EN
        push_g(1'b0, 1'b0, 5'd1, 32'd0, base + 1);
        push_v(1'b0, 5'd1, 32'hC0DE0001, 32'd0, base + 2);
        push_g(1'b0, 1'b0, 5'd1, 32'd0, base + 3);
        push_v(1'b0, 5'd1, 32'hC0DE0001, 32'd0, base + 4);
        push_g(1'b1, 1'b0, 5'd2, 32'd0, base + 5);
        push_v(1'b1, 5'd2, 32'hC0DE0001, 32'hC0DE0002, base + 6);
`else
        push_g(1'b0, 1'b0, 5'd1, 32'd0, base + 1);
        push_v(1'b0, 5'd1, 32'hC0DE0001, 32'd0, base + 2);
        push_g(1'b1, 1'b0, 5'd2, 32'd0, base + 3);
        push_v(1'b1, 5'd2, 32'hC0DE0001, 32'hC0DE0002, base + 4);
        push_g(1'b0, 1'b0, 5'd1, 32'd0, base + 5);
        push_v(1'b0, 5'd1, 32'hC0DE0001, 32'hC0DE0002, base + 6);
`endif
        n0 = 0;
        for (int k = 0; k < 20 && (req0 || req1); k++) begin
            @(negedge clk);
            if (gnt0) begin
                n0++;
                if (n0 == 2) req0 = 1'b0;
            end
            if (gnt1) req1 = 1'b0;
        end
        drain(20);

        // Back-to-back: master 1 raises Req during master 0's access and is sampled in DONE.
        base = cyc;
        req0 = 1'b1; we0 = 1'b0; dir0 = 5'd0;
        push_g(1'b0, 1'b0, 5'd0, 32'd0, base + 1);
        push_v(1'b0, 5'd0, 32'hC0DE0000, 32'hC0DE0002, base + 2);
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; dir1 = 5'd31;
        push_g(1'b1, 1'b0, 5'd31, 32'd0, base + 3);
        push_v(1'b1, 5'd31, 32'hC0DE0000, 32'hC0DE001F, base + 4);
        @(negedge clk);
        check("t4_busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("t4_busy_no_gap", 32'(busy), 32'd1);
        req1 = 1'b0;
        drain(10);

        // Reset in the middle of a write to address 7: write aborted, no Valid.
        base = cyc;
        req0 = 1'b1; we0 = 1'b1; dir0 = 5'd7; datoin0 = 32'h12345678;
        push_g(1'b0, 1'b1, 5'd7, 32'h12345678, base + 1);
        @(negedge clk);
        check("t5_we_in_access", 32'(ram_we), 32'd1);
        req0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5_we_drops", 32'(ram_we), 32'd0);
        check("t5_busy_drops", 32'(busy), 32'd0);
        check("t5_gnt_drops", 32'({gnt0, gnt1}), 32'd0);
        check("t5_datoout0_cleared", datoout0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("t5_no_valid", 32'({valid0, valid1}), 32'd0);
        rst = 1'b0;
        base = cyc;
        req0 = 1'b1; we0 = 1'b0; dir0 = 5'd7;
        req1 = 1'b1; we1 = 1'b0; dir1 = 5'd3;
        push_g(1'b0, 1'b0, 5'd7, 32'd0, base + 1);
        push_v(1'b0, 5'd7, 32'hC0DE0007, 32'd0, base + 2);
        push_g(1'b1, 1'b0, 5'd3, 32'd0, base + 3);
        push_v(1'b1, 5'd3, 32'hC0DE0007, 32'hC0DE0003, base + 4);
        for (int k = 0; k < 20 && (req0 || req1); k++) begin
            @(negedge clk);
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
        end
        drain(20);
        check("end_busy_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
